map_sprite_writer: RTL and testbench

//  Parametrised read-modify-write engine that moves N_SPR sprites (index 0 = pacman, 1..N_SPR-1 = ghosts)
//  in the row-organised map RAM. It initialises the RAM from a map ROM after reset and serialises sprite moves.
//  It also reports dot/pill consumption and sprite collisions. Sits between the location controllers/ghost AI
//  and map RAM port B.

---
 rtl/map_pkg.sv | 48 ++++
 rtl/map_cell_merge.sv | 32 +++
 rtl/map_sprite_writer.sv | 185 ++++++++++++++++++
 tb/tb_map_sprite_writer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared map cell codes, FSM states and sprite cell-rewrite helpers for the map RAM writer.
package map_pkg;

  localparam int CELL_W        = 4;
  localparam int MAP_W_DEFAULT = 40;
  localparam int MAP_H_DEFAULT = 30;

  typedef enum logic [CELL_W-1:0] {
    EMPTY      = 4'd0,
    WALL       = 4'd1,
    DOT        = 4'd2,
    PILL       = 4'd3,
    PAC        = 4'd4,
    GHOST      = 4'd5,
    GHOST_DOT  = 4'd6,
    GHOST_PILL = 4'd7
  } cell_e;

  typedef enum logic [2:0] {
    INIT_RD,
    INIT_WR,
    IDLE,
    RM_RD,
    RM_WR,
    PUT_RD,
    PUT_WR
  } state_e;

  // Leaving a cell restores whatever the sprite was standing on.
  function automatic cell_e ghost_remove(cell_e c);
    case (c)
      GHOST, PAC: ghost_remove = EMPTY;
      GHOST_DOT:  ghost_remove = DOT;
      GHOST_PILL: ghost_remove = PILL;
      default:    ghost_remove = c;
    endcase
  endfunction

  function automatic cell_e ghost_put(cell_e c);
    case (c)
      EMPTY, PAC: ghost_put = GHOST;
      DOT:        ghost_put = GHOST_DOT;
      PILL:       ghost_put = GHOST_PILL;
      default:    ghost_put = c;
    endcase
  endfunction

endpackage

// File: rtl/map_cell_merge.sv
// Combinational row splice: extracts the cell at a column and returns the row with a new cell in its place.
module map_cell_merge
  import map_pkg::*;
#(
  parameter int MAP_W = MAP_W_DEFAULT
) (
  input  logic [MAP_W*CELL_W-1:0]   row,
  input  logic [$clog2(MAP_W)-1:0]  col,
  input  cell_e                     new_cell,
  output logic [MAP_W*CELL_W-1:0]   merged_row,
  output cell_e                     old_cell
);

  localparam int ROW_W = MAP_W * CELL_W;
  localparam int XW    = $clog2(MAP_W);

  // Kept separate from the splice so the caller may derive new_cell from old_cell.
  always_comb begin
    old_cell = EMPTY;
    for (int c = 0; c < MAP_W; c++) begin
      if (col == XW'(c)) old_cell = cell_e'(row[ROW_W-1-CELL_W*c -: CELL_W]);
    end
  end

  always_comb begin
    merged_row = row;
    for (int c = 0; c < MAP_W; c++) begin
      if (col == XW'(c)) merged_row[ROW_W-1-CELL_W*c -: CELL_W] = new_cell;
    end
  end

endmodule

// File: rtl/map_sprite_writer.sv
// Map RAM writer: copies the map ROM into RAM after reset, then serialises sprite remove/put moves.
// Define MAP_WRITER_COLLIDE_EN to enable the pacman/ghost collide pulse.
module map_sprite_writer
  import map_pkg::*;
#(
  parameter  int MAP_W = MAP_W_DEFAULT,
  parameter  int MAP_H = MAP_H_DEFAULT,
  parameter  int N_SPR = 3,
  localparam int ROW_W = MAP_W * CELL_W,
  localparam int XW    = $clog2(MAP_W),
  localparam int YW    = $clog2(MAP_H)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [N_SPR*XW-1:0] curr_x,
  input  logic [N_SPR*YW-1:0] curr_y,
  input  logic [N_SPR*XW-1:0] next_x,
  input  logic [N_SPR*YW-1:0] next_y,
  output logic [YW-1:0]      rom_addr,
  input  logic [ROW_W-1:0]   rom_data,
  input  logic [ROW_W-1:0]   redata,
  output logic               wren,
  output logic [YW-1:0]      wraddr,
  output logic [ROW_W-1:0]   wrdata,
  output logic [N_SPR-1:0]   done,
  output logic               init_done,
  output logic               busy,
  output logic               dot_eaten,
  output logic               pill_eaten,
  output logic               collide
);

  localparam int SW = (N_SPR > 1) ? $clog2(N_SPR) : 1;

  state_e           state, state_nxt;
  logic [YW-1:0]    row, row_nxt;
  logic [SW-1:0]    sel, sel_nxt, cand;
  logic             skip, skip_nxt;
  logic             init_done_q, init_done_nxt;
  logic [N_SPR-1:0] done_q, done_c, pending, in_range;
  logic             any_pend;
  logic [XW-1:0]    sel_cx, sel_nx, merge_col;
  logic [YW-1:0]    sel_cy, sel_ny, wraddr_c;
  logic             wren_c, dot_c, pill_c;
  cell_e            old_cell, new_cell;
  logic [ROW_W-1:0] merged_row;

  assign sel_cx = curr_x[sel*XW +: XW];
  assign sel_cy = curr_y[sel*YW +: YW];
  assign sel_nx = next_x[sel*XW +: XW];
  assign sel_ny = next_y[sel*YW +: YW];

  // A sprite that just completed is masked for one cycle while upstream catches curr up to next.
  always_comb begin
    pending  = '0;
    in_range = '0;
    for (int i = 0; i < N_SPR; i++) begin
      pending[i]  = ((curr_x[i*XW +: XW] != next_x[i*XW +: XW]) ||
                     (curr_y[i*YW +: YW] != next_y[i*YW +: YW])) && !done_q[i];
      in_range[i] = (32'(curr_x[i*XW +: XW]) < MAP_W) && (32'(next_x[i*XW +: XW]) < MAP_W) &&
                    (32'(curr_y[i*YW +: YW]) < MAP_H) && (32'(next_y[i*YW +: YW]) < MAP_H);
    end
  end

  always_comb begin
    any_pend = 1'b0;
    cand     = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (pending[i]) begin
        any_pend = 1'b1;
        cand     = SW'(i);
      end
    end
  end

  assign merge_col = (state == RM_WR) ? sel_cx : sel_nx;
  assign new_cell  = (state == RM_WR) ? ghost_remove(old_cell) :
                     ((sel == '0) ? PAC : ghost_put(old_cell));

  map_cell_merge #(.MAP_W(MAP_W)) u_merge (
    .row        (redata),
    .col        (merge_col),
    .new_cell   (new_cell),
    .merged_row (merged_row),
    .old_cell   (old_cell)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= INIT_RD;
      row         <= '0;
      sel         <= '0;
      skip        <= 1'b0;
      init_done_q <= 1'b0;
      done_q      <= '0;
    end else begin
      state       <= state_nxt;
      row         <= row_nxt;
      sel         <= sel_nxt;
      skip        <= skip_nxt;
      init_done_q <= init_done_nxt;
      done_q      <= done_c;
    end
  end

  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    sel_nxt       = sel;
    skip_nxt      = skip;
    init_done_nxt = init_done_q;
    wraddr_c      = '0;
    wren_c        = 1'b0;
    done_c        = '0;
    dot_c         = 1'b0;
    pill_c        = 1'b0;
    case (state)
      INIT_RD: begin
        wraddr_c  = row;
        state_nxt = INIT_WR;
      end
      INIT_WR: begin
        wraddr_c = row;
        wren_c   = 1'b1;
        if (row == YW'(MAP_H - 1)) begin
          init_done_nxt = 1'b1;
          state_nxt     = IDLE;
        end else begin
          row_nxt   = row + 1'b1;
          state_nxt = INIT_RD;
        end
      end
      IDLE: begin
        // Out-of-range coordinates bypass the RAM entirely and just acknowledge.
        if (any_pend) begin
          sel_nxt   = cand;
          skip_nxt  = !in_range[cand];
          state_nxt = in_range[cand] ? RM_RD : PUT_WR;
        end
      end
      RM_RD: begin
        wraddr_c  = sel_cy;
        state_nxt = RM_WR;
      end
      RM_WR: begin
        wraddr_c  = sel_cy;
        wren_c    = 1'b1;
        state_nxt = PUT_RD;
      end
      PUT_RD: begin
        wraddr_c  = sel_ny;
        state_nxt = PUT_WR;
      end
      PUT_WR: begin
        wraddr_c  = sel_ny;
        wren_c    = !skip && (old_cell != WALL);
        done_c    = N_SPR'(1) << sel;
        dot_c     = !skip && (sel == '0) && (old_cell == DOT);
        pill_c    = !skip && (sel == '0) && (old_cell == PILL);
        state_nxt = IDLE;
      end
      default: state_nxt = INIT_RD;
    endcase
  end

  // Reset masks every strobe so an interrupted move never lands a partial write.
  assign wren       = wren_c & ~reset;
  assign wraddr     = reset ? '0 : wraddr_c;
  assign rom_addr   = reset ? '0 : row;
  assign wrdata     = (state == INIT_WR) ? rom_data : merged_row;
  assign done       = reset ? '0 : done_c;
  assign dot_eaten  = dot_c & ~reset;
  assign pill_eaten = pill_c & ~reset;
  assign init_done  = init_done_q & ~reset;
  assign busy       = reset || (state != IDLE);

`ifdef MAP_WRITER_COLLIDE_EN
  assign collide = !reset && (state == PUT_WR) && !skip &&
                   (((sel == '0) && (old_cell inside {GHOST, GHOST_DOT, GHOST_PILL})) ||
                    ((sel != '0) && (old_cell == PAC)));
`else
  assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_map_sprite_writer.sv
// Bench for map_sprite_writer: ROM/RAM models, table of sprite moves with a pulse scoreboard, reset/init corners.
module tb_map_sprite_writer;
  import map_pkg::*;

  localparam int MAP_W = 40;
  localparam int MAP_H = 30;
  localparam int N_SPR = 3;
  localparam int XW    = 6;
  localparam int YW    = 5;
  localparam int ROW_W = MAP_W * CELL_W;
`ifdef MAP_WRITER_COLLIDE_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  typedef struct {
    string name;
    int idx, cx, cy, nx, ny, src, dst;
    bit dot, pill, coll;
    int lat;
  } vec_t;

  typedef struct {
    string name;
    logic [N_SPR-1:0] mask;
    bit dot, pill, coll;
    int lat;
  } exp_t;

  logic CLOCK_50, reset;
  logic [N_SPR*XW-1:0] curr_x, next_x;
  logic [N_SPR*YW-1:0] curr_y, next_y;
  logic [YW-1:0] rom_addr, wraddr;
  logic [ROW_W-1:0] rom_data, redata, wrdata;
  logic wren, init_done, busy, dot_eaten, pill_eaten, collide;
  logic [N_SPR-1:0] done;

  logic [ROW_W-1:0] rom [MAP_H];
  logic [ROW_W-1:0] ram [MAP_H];
  logic [ROW_W-1:0] exp_ram [MAP_H];
  int cx_a [N_SPR], cy_a [N_SPR], nx_a [N_SPR], ny_a [N_SPR];
  exp_t sb_q [$];
  vec_t vec_q [$];
  int checks = 0;
  int failures = 0;

  map_sprite_writer #(.MAP_W(MAP_W), .MAP_H(MAP_H), .N_SPR(N_SPR)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .curr_x(curr_x), .curr_y(curr_y), .next_x(next_x), .next_y(next_y),
    .rom_addr(rom_addr), .rom_data(rom_data), .redata(redata),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata), .done(done),
    .init_done(init_done), .busy(busy), .dot_eaten(dot_eaten),
    .pill_eaten(pill_eaten), .collide(collide)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // ROM and RAM both return data one cycle after the address.
  always @(posedge CLOCK_50) begin
    if (wren && (32'(wraddr) < MAP_H)) ram[wraddr] <= wrdata;
    redata   <= (32'(wraddr) < MAP_H) ? ram[wraddr] : '0;
    rom_data <= (32'(rom_addr) < MAP_H) ? rom[rom_addr] : '0;
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int cell_at(input int x, input int y);
    return int'(ram[y][ROW_W-1-CELL_W*x -: CELL_W]);
  endfunction

  task automatic set_rom_cell(input int x, input int y, input cell_e c);
    rom[y][ROW_W-1-CELL_W*x -: CELL_W] = c;
  endtask

  task automatic set_exp_cell(input int x, input int y, input int c);
    exp_ram[y][ROW_W-1-CELL_W*x -: CELL_W] = CELL_W'(c);
  endtask

  task automatic drive_pos();
    for (int i = 0; i < N_SPR; i++) begin
      curr_x[i*XW +: XW] = XW'(cx_a[i]);
      curr_y[i*YW +: YW] = YW'(cy_a[i]);
      next_x[i*XW +: XW] = XW'(nx_a[i]);
      next_y[i*YW +: YW] = YW'(ny_a[i]);
    end
  endtask

  task automatic check_map(input string name);
    int bad = 0;
    for (int r = 0; r < MAP_H; r++) if (ram[r] !== exp_ram[r]) bad++;
    check_val(name, bad, 0);
  endtask

  task automatic wait_init();
    int c = 0;
    int wr_cnt = 0;
    int bad_wr = 0;
    bit seen = 1'b0;
    while (!seen && c < 4*MAP_H) begin
      @(negedge CLOCK_50);
      if (init_done) seen = 1'b1;
      else begin
        if (wren) begin
          wr_cnt++;
          if (c % 2 == 0) bad_wr++;
        end
        c++;
      end
    end
    check_val("init_cycles", c, 2*MAP_H);
    check_val("init_wren_in_rd", bad_wr, 0);
    check_val("init_write_count", wr_cnt, MAP_H);
    check_val("init_busy_low", busy, 0);
    for (int r = 0; r < MAP_H; r++) exp_ram[r] = rom[r];
    check_map("init_ram_eq_rom");
    @(posedge CLOCK_50); #1;
  endtask

  task automatic reset_and_init();
    reset = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_val("rst_wren", wren, 0);
    check_val("rst_done", done, 0);
    check_val("rst_init_done", init_done, 0);
    check_val("rst_busy", busy, 1);
    check_val("rst_wraddr", wraddr, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    check_val("rst_pulses", {dot_eaten, pill_eaten, collide}, 0);
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    wait_init();
  endtask

  task automatic apply_stimulus(input vec_t v);
    exp_t e;
    e.name = v.name;
    e.mask = '0;
    e.mask[v.idx] = 1'b1;
    e.dot  = v.dot;
    e.pill = v.pill;
    e.coll = v.coll & COLL_EN;
    e.lat  = v.lat;
    sb_q.push_back(e);
    cx_a[v.idx] = v.cx; cy_a[v.idx] = v.cy;
    nx_a[v.idx] = v.nx; ny_a[v.idx] = v.ny;
    drive_pos();
  endtask

  // Pops one scoreboard entry per done pulse; upstream then catches curr up to next.
  task automatic check_output(input int n_events, input int max_cyc);
    int got = 0;
    int cyc = 0;
    bit spurious = 1'b0;
    logic [N_SPR-1:0] m;
    exp_t e;
    while (got < n_events && cyc < max_cyc) begin
      @(negedge CLOCK_50);
      cyc++;
      m = done;
      if (m != '0) begin
        if (sb_q.size() == 0) check_val("unexpected_done", m, 0);
        else begin
          e = sb_q.pop_front();
          check_val({e.name, "_done_mask"}, m, e.mask);
          check_val({e.name, "_pulses"}, {dot_eaten, pill_eaten, collide}, {e.dot, e.pill, e.coll});
          if (e.lat > 0) check_val({e.name, "_latency"}, cyc, e.lat);
        end
        got++;
      end else if (dot_eaten || pill_eaten || collide) spurious = 1'b1;
      @(posedge CLOCK_50); #1;
      for (int i = 0; i < N_SPR; i++) begin
        if (m[i]) begin
          cx_a[i] = nx_a[i];
          cy_a[i] = ny_a[i];
        end
      end
      drive_pos();
    end
    check_val("done_events", got, n_events);
    check_val("spurious_pulse", spurious, 0);
    sb_q.delete();
    @(posedge CLOCK_50); #1;
  endtask

  task automatic add_vec(input string name, input int idx, input int cx, input int cy, input int nx, input int ny,
                         input int src, input int dst, input bit dot, input bit pill, input bit coll, input int lat);
    vec_t v;
    v.name = name; v.idx = idx; v.cx = cx; v.cy = cy; v.nx = nx; v.ny = ny;
    v.src = src; v.dst = dst; v.dot = dot; v.pill = pill; v.coll = coll; v.lat = lat;
    vec_q.push_back(v);
  endtask

  initial begin
    exp_t e;
    vec_t v;
    reset = 1'b1;
    for (int r = 0; r < MAP_H; r++) begin
      ram[r] = '0;
      for (int c = 0; c < MAP_W; c++) begin
        if (r >= 10) set_rom_cell(c, r, cell_e'(CELL_W'((r + c) % 3)));
        else set_rom_cell(c, r, (c == 0 || c == MAP_W-1) ? WALL : EMPTY);
      end
    end
    set_rom_cell(5, 1, PAC);   set_rom_cell(6, 1, DOT);
    set_rom_cell(3, 4, GHOST_PILL);
    set_rom_cell(8, 2, PILL);  set_rom_cell(10, 3, WALL);
    set_rom_cell(12, 6, GHOST); set_rom_cell(12, 7, DOT);
    cx_a[0] = 5;  cy_a[0] = 1;
    cx_a[1] = 3;  cy_a[1] = 4;
    cx_a[2] = 12; cy_a[2] = 6;
    for (int i = 0; i < N_SPR; i++) begin nx_a[i] = cx_a[i]; ny_a[i] = cy_a[i]; end
    drive_pos();

    reset_and_init();

    //      name         idx cx cy nx  ny  src         dst         dot pill coll lat
    add_vec("pac_dot",    0, 5, 1, 6,  1, EMPTY,      PAC,        1, 0, 0, 5);
    add_vec("g1_pill",    1, 3, 4, 3,  5, PILL,       GHOST,      0, 0, 0, 5);
    add_vec("pac_empty",  0, 6, 1, 7,  1, EMPTY,      PAC,        0, 0, 0, 5);
    add_vec("pac_pill",   0, 7, 1, 8,  2, EMPTY,      PAC,        0, 1, 0, 5);
    add_vec("pac_wall",   0, 8, 2, 10, 3, EMPTY,      WALL,       0, 0, 0, 5);
    add_vec("g2_on_dot",  2, 12, 6, 12, 7, EMPTY,     GHOST_DOT,  0, 0, 0, 5);
    add_vec("g2_off_dot", 2, 12, 7, 12, 6, DOT,       GHOST,      0, 0, 0, 5);
    add_vec("g1_same_row",1, 3, 5, 4,  5, EMPTY,      GHOST,      0, 0, 0, 5);
    add_vec("g1_next_oor",1, 4, 5, 40, 5, GHOST,      -1,         0, 0, 0, 0);
    add_vec("g1_curr_oor",1, 40, 5, 5, 5, -1,         EMPTY,      0, 0, 0, 0);
    add_vec("pac_off_wall",0, 10, 3, 11, 6, WALL,     PAC,        0, 0, 0, 5);
    add_vec("pac_on_ghost",0, 11, 6, 12, 6, EMPTY,    PAC,        0, 0, 1, 5);

    for (int t = 0; t < vec_q.size(); t++) begin
      v = vec_q[t];
      apply_stimulus(v);
      check_output(1, 20);
      if (v.src >= 0) begin
        check_val({v.name, "_src_cell"}, cell_at(v.cx, v.cy), v.src);
        set_exp_cell(v.cx, v.cy, v.src);
      end
      if (v.dst >= 0) begin
        check_val({v.name, "_dst_cell"}, cell_at(v.nx, v.ny), v.dst);
        set_exp_cell(v.nx, v.ny, v.dst);
      end
      check_map({v.name, "_map_rows"});
    end

    // Pacman and ghost2 request together: pacman wins, ghost2 follows and lands on pacman.
    e.name = "conc_pac";  e.mask = 3'b001; e.dot = 0; e.pill = 0; e.coll = 0;       e.lat = 5;
    sb_q.push_back(e);
    e.name = "conc_g2";   e.mask = 3'b100; e.dot = 0; e.pill = 0; e.coll = COLL_EN; e.lat = 10;
    sb_q.push_back(e);
    nx_a[0] = 13; ny_a[0] = 6;
    nx_a[2] = 13; ny_a[2] = 6;
    drive_pos();
    check_output(2, 30);
    check_val("conc_old_cell", cell_at(12, 6), EMPTY);
    check_val("conc_new_cell", cell_at(13, 6), GHOST);
    set_exp_cell(12, 6, EMPTY);
    set_exp_cell(13, 6, GHOST);
    check_map("conc_map_rows");

    // Reset lands while the remove write is being issued.
    nx_a[0] = 14; ny_a[0] = 6;
    drive_pos();
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b1;
    @(negedge CLOCK_50);
    check_val("rst_rmwr_wren", wren, 0);
    check_val("rst_rmwr_done", done, 0);
    @(posedge CLOCK_50); #1;
    @(negedge CLOCK_50);
    check_val("rst_next_wren", wren, 0);
    check_val("rst_next_busy", busy, 1);
    check_val("rst_next_rom_addr", rom_addr, 0);
    for (int i = 0; i < N_SPR; i++) begin nx_a[i] = cx_a[i]; ny_a[i] = cy_a[i]; end
    drive_pos();
    reset_and_init();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
